// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths, fetch queue entry type and PC step for the fetch stage.
package inst_fetch_unit_pkg;
    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: imem and decode-side signals of the fetch stage; FETCH_PERF_EN adds perf counters.
interface inst_fetch_unit_if;
    import inst_fetch_unit_pkg::*;
    logic [XLEN-1:0]    mem_pc;
    logic [INSTR_W-1:0] mem_instr;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]        fetch_count;
    logic [31:0]        stall_count;
    modport master (output mem_pc, out_valid, out_pc, out_instr, fetch_count, stall_count,
                    input mem_instr, redirect_valid, redirect_pc, out_ready);
    modport slave  (input mem_pc, out_valid, out_pc, out_instr, fetch_count, stall_count,
                    output mem_instr, redirect_valid, redirect_pc, out_ready);
`else
    modport master (output mem_pc, out_valid, out_pc, out_instr,
                    input mem_instr, redirect_valid, redirect_pc, out_ready);
    modport slave  (input mem_pc, out_valid, out_pc, out_instr,
                    output mem_instr, redirect_valid, redirect_pc, out_ready);
`endif
endinterface

// File: rtl/inst_fetch_unit_fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch_entry_t with push, pop and flush; head reads as 0 when empty.
module fetch_queue
    import inst_fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic         o_valid,
    output logic         o_full
);
    fetch_entry_t r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wptr] <= i_entry;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop) r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(i_push) - 2'(i_pop);
        end
    end

    always_comb begin
        o_valid = r_count != 2'd0;
        o_full  = r_count == 2'd2;
        o_head  = o_valid ? r_mem[r_rptr] : '0;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, fills a 2-entry fetch queue from imem and hands {pc, instr} to decode.
// Optional perf counters (fetch_count, stall_count) are built when FETCH_PERF_EN is defined.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              MEM_BYTES = 32
) (
    input  logic               clk,
    input  logic               reset,
    inst_fetch_unit_if.master  bus
);
    localparam logic [XLEN-1:0] PC_MASK = XLEN'(MEM_BYTES - 1) & ~32'h3;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            w_push;
    logic            w_pop;
    logic            w_valid;
    logic            w_full;
    fetch_entry_t    w_head;

    // A redirect both flushes the queue and suppresses the push and pop of its cycle.
    always_comb begin
        w_pop     = w_valid && bus.out_ready && !bus.redirect_valid;
        w_push    = !reset && !bus.redirect_valid && (!w_full || w_pop);
        w_pc_next = reset              ? RESET_PC :
                    bus.redirect_valid ? bus.redirect_pc & PC_MASK :
                    w_push             ? (r_pc + PC_STEP) & PC_MASK : r_pc;
    end

    always_ff @(posedge clk)
        r_pc <= w_pc_next;

    fetch_queue u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_entry ('{pc: r_pc, instr: bus.mem_instr}),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_full  (w_full)
    );

    assign bus.mem_pc    = r_pc;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            r_fetch_count <= r_fetch_count + 32'(w_push);
            r_stall_count <= r_stall_count + 32'(w_valid && !bus.out_ready && !bus.redirect_valid);
        end
    end

    assign bus.fetch_count = r_fetch_count;
    assign bus.stall_count = r_stall_count;
`endif
endmodule
